// File: rtl/mmio_button_led_port.sv
// Memory-mapped button/switch/LED port beside data RAM: debounced buttons with
// sticky press events (read-to-clear), synchronised switches, and a writable LED register.
module mmio_button_led_port #(
    parameter int unsigned NUM_BTN      = 4,
    parameter int unsigned SW_W         = 16,
    parameter int unsigned LED_W        = 16,
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned BTN_ADDR     = 4096,
    parameter int unsigned SW_ADDR      = 4097,
    parameter int unsigned LED_ADDR     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]    sw_raw,
    input  logic [31:0]        addr,
    input  logic               wren,
    input  logic               rd_en,
    input  logic [31:0]        wdata,
    input  logic [31:0]        mem_q,
    output logic [31:0]        q_out,
    output logic [LED_W-1:0]   led,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               evt_any
);

    // Bus semantics: wren and rd_en are single-cycle strobes qualified by addr on
    // the same posedge; there is no backpressure, every strobe completes that cycle.
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [31:0]     BTN_A    = 32'(BTN_ADDR);
    localparam logic [31:0]     SW_A     = 32'(SW_ADDR);
    localparam logic [31:0]     LED_A    = 32'(LED_ADDR);

    logic [NUM_BTN-1:0] btn_meta, btn_sync;
    logic [SW_W-1:0]    sw_meta, sw_sync;
    logic [NUM_BTN-1:0] level_q, pending_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [LED_W-1:0]   led_q;

    logic [NUM_BTN-1:0] toggle, rise, evt_sel, clr_mask;
    logic [31:0]        evt_code;
    logic               btn_read, led_write;
    logic               unused_wdata;

    assign unused_wdata = ^wdata;
    assign btn_read     = rd_en && (addr == BTN_A);
    assign led_write    = wren && (addr == LED_A);

    // A button toggles on the last of DEBOUNCE_CYC consecutive differing cycles.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            toggle[i] = (btn_sync[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
        end
    end

    assign rise = toggle & ~level_q;

    // Lowest-numbered pending button wins; the code is its index plus one.
    always_comb begin
        evt_code = '0;
        evt_sel  = '0;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                evt_code   = 32'(i + 1);
                evt_sel    = '0;
                evt_sel[i] = 1'b1;
            end
        end
    end

    assign clr_mask = btn_read ? evt_sel : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            level_q   <= '0;
            pending_q <= '0;
            led_q     <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
            sw_meta   <= sw_raw;
            sw_sync   <= sw_meta;
            // A new press on the same edge as its read-clear keeps the bit set.
            pending_q <= (pending_q & ~clr_mask) | rise;
            if (led_write) begin
                led_q <= wdata[LED_W-1:0];
            end
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (btn_sync[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (toggle[i]) begin
                    cnt_q[i]   <= '0;
                    level_q[i] <= ~level_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (addr == BTN_A) begin
            q_out = evt_code;
        end else if (addr == SW_A) begin
            q_out = 32'(sw_sync);
        end else if (addr == LED_A) begin
            q_out = 32'(led_q);
        end else begin
            q_out = mem_q;
        end
    end

    assign led       = led_q;
    assign btn_level = level_q;
    assign evt_any   = |pending_q;

endmodule

// File: tb/tb_mmio_button_led_port.sv
// Directed bench for mmio_button_led_port with a short debounce (4 cycles), so a
// clean press reaches btn_level on the 6th posedge after the raw edge.
module tb_mmio_button_led_port;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [15:0] sw_raw;
    logic [31:0] addr;
    logic        wren;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] mem_q;
    logic [31:0] q_out;
    logic [15:0] led;
    logic [3:0]  btn_level;
    logic        evt_any;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    mmio_button_led_port #(
        .NUM_BTN(4), .SW_W(16), .LED_W(16), .DEBOUNCE_CYC(4),
        .BTN_ADDR(4096), .SW_ADDR(4097), .LED_ADDR(1)
    ) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .addr(addr), .wren(wren), .rd_en(rd_en), .wdata(wdata), .mem_q(mem_q),
        .q_out(q_out), .led(led), .btn_level(btn_level), .evt_any(evt_any)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_addr(input logic [31:0] a);
        addr = a;
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_load(input string tag);
        logic [31:0] expv;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed=%h expected=<empty queue>", tag, q_out);
        end else begin
            expv = exp_q.pop_front();
            check(tag, q_out, expv);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        sw_raw  = 16'h5A5A;
        addr    = 32'd0;
        wren    = 1'b0;
        rd_en   = 1'b0;
        wdata   = '0;
        mem_q   = 32'h0;
        tick(3);

        // reset state
        check("rst_led", 32'(led), 32'h0);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_evt_any", 32'(evt_any), 32'h0);
        set_addr(32'd4096);
        check("rst_btn_code", q_out, 32'h0);
        set_addr(32'd4097);
        check("rst_sw", q_out, 32'h0);

        reset = 1'b0;
        tick(2);
        check("sw_sync", q_out, 32'h0000_5A5A);
        sw_raw = 16'h00FF;
        tick(1);
        check("sw_one_flop_old", q_out, 32'h0000_5A5A);
        tick(1);
        check("sw_two_flop_new", q_out, 32'h0000_00FF);

        // 1. clean press of button 0
        btn_raw[0] = 1'b1;
        tick(5);
        check("t1_level_before", 32'(btn_level), 32'h0);
        tick(1);
        check("t1_level_rise", 32'(btn_level), 32'h1);
        check("t1_evt_any", 32'(evt_any), 32'h1);
        set_addr(32'd4096);
        rd_en = 1'b1;
        #1;
        check("t1_load_code", q_out, 32'd1);
        tick(1);
        rd_en = 1'b0;
        #1;
        check("t1_after_clear", q_out, 32'd0);
        check("t1_evt_any_clear", 32'(evt_any), 32'h0);
        btn_raw[0] = 1'b0;
        tick(8);
        check("t1_release_level", 32'(btn_level), 32'h0);
        check("t1_release_no_evt", 32'(evt_any), 32'h0);

        // 2. 3-cycle glitch on button 1 is rejected
        btn_raw[1] = 1'b1;
        tick(3);
        btn_raw[1] = 1'b0;
        tick(8);
        check("t2_glitch_level", 32'(btn_level), 32'h0);
        check("t2_glitch_evt", 32'(evt_any), 32'h0);
        check("t2_glitch_code", q_out, 32'h0);

        // 3. buttons 2 then 0; re-press of 2 while pending is absorbed
        btn_raw[2] = 1'b1;
        tick(2);
        btn_raw[0] = 1'b1;
        tick(10);
        check("t3_levels", 32'(btn_level), 32'h5);
        btn_raw[2] = 1'b0;
        tick(8);
        btn_raw[2] = 1'b1;
        tick(8);
        check("t3_levels_again", 32'(btn_level), 32'h5);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd0);
        rd_en = 1'b1;
        #1;
        check_load("t3_load_first");
        tick(1);
        check_load("t3_load_second");
        tick(1);
        check_load("t3_load_third");
        tick(1);
        rd_en = 1'b0;
        check("t3_evt_any_done", 32'(evt_any), 32'h0);
        btn_raw = '0;
        tick(8);

        // 4. LED store/load, RAM passthrough, ignored store to the button address
        set_addr(32'd1);
        wdata = 32'h1234_ABCD;
        wren  = 1'b1;
        tick(1);
        wren = 1'b0;
        check("t4_led", 32'(led), 32'h0000_ABCD);
        check("t4_led_load", q_out, 32'h0000_ABCD);
        mem_q = 32'hDEAD_BEEF;
        set_addr(32'd5);
        check("t4_ram_pass", q_out, 32'hDEAD_BEEF);
        set_addr(32'd4096);
        wdata = 32'h0000_FFFF;
        wren  = 1'b1;
        tick(1);
        set_addr(32'd4097);
        tick(1);
        wren = 1'b0;
        check("t4_led_hold", 32'(led), 32'h0000_ABCD);

        // 5. read-clear on the same edge as a new press of button 0: set wins
        btn_raw[0] = 1'b1;
        tick(6);
        btn_raw[0] = 1'b0;
        tick(8);
        check("t5_pending_kept", 32'(evt_any), 32'h1);
        btn_raw[0] = 1'b1;
        tick(5);
        set_addr(32'd4096);
        rd_en = 1'b1;
        #1;
        check("t5_code_before", q_out, 32'd1);
        tick(1);
        rd_en = 1'b0;
        #1;
        check("t5_level_rise", 32'(btn_level), 32'h1);
        check("t5_set_wins", q_out, 32'd1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        #1;
        check("t5_cleared", q_out, 32'd0);
        btn_raw[0] = 1'b0;
        tick(8);

        // 6. reset mid-debounce with an event pending
        btn_raw[1] = 1'b1;
        tick(6);
        check("t6_pending1", q_out, 32'd2);
        btn_raw[1] = 1'b0;
        btn_raw[3] = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("t6_rst_level", 32'(btn_level), 32'h0);
        check("t6_rst_evt", 32'(evt_any), 32'h0);
        check("t6_rst_led", 32'(led), 32'h0);
        check("t6_rst_code", q_out, 32'h0);
        reset = 1'b0;
        tick(5);
        check("t6_level_before", 32'(btn_level), 32'h0);
        tick(1);
        check("t6_level_rise", 32'(btn_level), 32'h8);
        check("t6_code", q_out, 32'd4);

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
